// File: rtl/msrv32_target_adder_pipe_pkg.sv
// Shared definitions for the msrv32 target adder pipeline: mode encodings and default width.
package msrv32_pkg;

    localparam int unsigned XLEN_DEF = 32;

    typedef enum logic [1:0] {
        MODE_ADD   = 2'b00,
        MODE_JALR  = 2'b01,
        MODE_PCREL = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

endpackage

// File: rtl/msrv32_target_adder_pipe_if.sv
// Handshake/operand bundle of the target adder pipeline; master drives operands, slave is the adder.
interface msrv32_target_adder_pipe_if
    import msrv32_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
);
    logic            flush_in;
    logic            in_valid_in;
    logic            in_ready_out;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] rs_1_in;
    logic [XLEN-1:0] imm_in;
    logic            iadder_src_in;
    logic [1:0]      mode_in;
    logic            out_valid_out;
    logic            out_ready_in;
    logic [XLEN-1:0] iadder_out;
    logic            misalign_out;

    modport master (
        output flush_in, in_valid_in, pc_in, rs_1_in, imm_in, iadder_src_in, mode_in, out_ready_in,
        input  in_ready_out, out_valid_out, iadder_out, misalign_out
    );

    modport slave (
        input  flush_in, in_valid_in, pc_in, rs_1_in, imm_in, iadder_src_in, mode_in, out_ready_in,
        output in_ready_out, out_valid_out, iadder_out, misalign_out
    );
endinterface

// File: rtl/msrv32_target_adder_pipe_stage.sv
// One valid/payload pipeline register with ready/valid handshake on both sides.
module msrv32_pipe_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Load when empty or when the successor drains us this same cycle.
    assign o_ready = !r_valid || i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/msrv32_target_adder_pipe.sv
// Pipelined branch/jump target adder (1 or 2 stages); MSRV32_TADD_MISALIGN_EN enables the misalign flag.
module msrv32_target_adder_pipe
    import msrv32_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input logic                       ms_riscv32_mp_clk_in,
    input logic                       ms_riscv32_mp_rst_in,
    msrv32_target_adder_pipe_if.slave tadd
);
    function automatic logic [XLEN-1:0] f_target(input logic [XLEN-1:0] base,
                                                 input logic [XLEN-1:0] imm,
                                                 input mode_e           mode);
        logic [XLEN-1:0] sum;
        sum = base + imm;
        if (mode == MODE_JALR) begin
            sum[0] = 1'b0;
        end
        return sum;
    endfunction

    mode_e           w_mode;
    logic [XLEN-1:0] w_base;
    logic            w_s0_ready;
    logic            w_out_valid;
    logic [XLEN-1:0] w_out_data;

    assign w_mode = mode_e'(tadd.mode_in);
    assign w_base = (w_mode == MODE_PCREL || !tadd.iadder_src_in) ? tadd.pc_in : tadd.rs_1_in;

    if (PIPE_DEPTH == 1) begin : g_depth1
        logic [XLEN-1:0] w_tgt;
        assign w_tgt = f_target(w_base, tadd.imm_in, w_mode);

        msrv32_pipe_stage #(.WIDTH(XLEN)) u_stage_out (
            .i_clk   (ms_riscv32_mp_clk_in),
            .i_rst   (ms_riscv32_mp_rst_in),
            .i_flush (tadd.flush_in),
            .i_valid (tadd.in_valid_in),
            .o_ready (w_s0_ready),
            .i_data  (w_tgt),
            .o_valid (w_out_valid),
            .i_ready (tadd.out_ready_in),
            .o_data  (w_out_data)
        );
    end else begin : g_depth2
        localparam int unsigned S1_W = 2 * XLEN + 2;

        logic [S1_W-1:0] w_s1_in;
        logic [S1_W-1:0] w_s1_data;
        logic            w_s1_valid;
        logic            w_s2_ready;
        logic [XLEN-1:0] w_s2_in;

        // Stage 1 holds {base, imm, mode}; the add happens between stages.
        assign w_s1_in = {w_base, tadd.imm_in, w_mode};
        assign w_s2_in = f_target(w_s1_data[S1_W-1 -: XLEN], w_s1_data[XLEN+1 -: XLEN],
                                  mode_e'(w_s1_data[1:0]));

        msrv32_pipe_stage #(.WIDTH(S1_W)) u_stage_op (
            .i_clk   (ms_riscv32_mp_clk_in),
            .i_rst   (ms_riscv32_mp_rst_in),
            .i_flush (tadd.flush_in),
            .i_valid (tadd.in_valid_in),
            .o_ready (w_s0_ready),
            .i_data  (w_s1_in),
            .o_valid (w_s1_valid),
            .i_ready (w_s2_ready),
            .o_data  (w_s1_data)
        );

        msrv32_pipe_stage #(.WIDTH(XLEN)) u_stage_out (
            .i_clk   (ms_riscv32_mp_clk_in),
            .i_rst   (ms_riscv32_mp_rst_in),
            .i_flush (tadd.flush_in),
            .i_valid (w_s1_valid),
            .o_ready (w_s2_ready),
            .i_data  (w_s2_in),
            .o_valid (w_out_valid),
            .i_ready (tadd.out_ready_in),
            .o_data  (w_out_data)
        );
    end

    assign tadd.in_ready_out  = !ms_riscv32_mp_rst_in && !tadd.flush_in && w_s0_ready;
    assign tadd.out_valid_out = w_out_valid;
    assign tadd.iadder_out    = w_out_data;

`ifdef MSRV32_TADD_MISALIGN_EN
    assign tadd.misalign_out = w_out_data[1] | w_out_data[0];
`else
    assign tadd.misalign_out = 1'b0;
`endif
endmodule

// File: tb/tb_msrv32_target_adder_pipe.sv
// Directed bench for msrv32_target_adder_pipe with a scoreboard fed at input handshakes.
module tb_msrv32_target_adder_pipe;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned PIPE_DEPTH = 2;

    typedef struct packed {
        logic            mis;
        logic [XLEN-1:0] tgt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t sbq[$];

    logic            stall_prev = 1'b0;
    logic [XLEN-1:0] prev_data  = '0;
    logic            prev_mis   = 1'b0;

    msrv32_target_adder_pipe_if #(.XLEN(XLEN)) tadd ();

    msrv32_target_adder_pipe #(.XLEN(XLEN), .PIPE_DEPTH(PIPE_DEPTH)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .tadd                 (tadd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rs1,
                                   input logic [XLEN-1:0] imm, input logic src,
                                   input logic [1:0] mode);
        logic [XLEN-1:0] base;
        logic [XLEN-1:0] sum;
        exp_t            e;
        base = (src && mode != 2'b10) ? rs1 : pc;
        sum  = base + imm;
        if (mode == 2'b01) sum[0] = 1'b0;
        e.tgt = sum;
`ifdef MSRV32_TADD_MISALIGN_EN
        e.mis = sum[1] | sum[0];
`else
        e.mis = 1'b0;
`endif
        return e;
    endfunction

    // Scoreboard monitor: sampled on the falling edge, between active edges.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", tadd.out_valid_out, 1'b1);
                chk("hold_data", tadd.iadder_out, prev_data);
                chk("hold_mis", tadd.misalign_out, prev_mis);
            end
            if (tadd.flush_in) begin
                chk("flush_ready", tadd.in_ready_out, 1'b0);
                sbq.delete();
                stall_prev = 1'b0;
            end else begin
                if (tadd.out_valid_out && tadd.out_ready_in) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_out", tadd.out_valid_out, 1'b0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("sb_target", tadd.iadder_out, e.tgt);
                        chk("sb_misalign", tadd.misalign_out, e.mis);
                    end
                end
                if (tadd.in_valid_in && tadd.in_ready_out)
                    sbq.push_back(model(tadd.pc_in, tadd.rs_1_in, tadd.imm_in,
                                        tadd.iadder_src_in, tadd.mode_in));
                stall_prev = tadd.out_valid_out && !tadd.out_ready_in;
                prev_data  = tadd.iadder_out;
                prev_mis   = tadd.misalign_out;
            end
        end
    end

    task automatic send(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rs1,
                        input logic [XLEN-1:0] imm, input logic src, input logic [1:0] mode);
        int unsigned n = 0;
        tadd.pc_in         = pc;
        tadd.rs_1_in       = rs1;
        tadd.imm_in        = imm;
        tadd.iadder_src_in = src;
        tadd.mode_in       = mode;
        tadd.in_valid_in   = 1'b1;
        @(negedge clk);
        while (!tadd.in_ready_out && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!tadd.in_ready_out) chk("accept_timeout", tadd.in_ready_out, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tadd.in_valid_in = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int unsigned n = 0;
        while (tadd.out_valid_out !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (tadd.out_valid_out !== 1'b1) chk(tag, tadd.out_valid_out, 1'b1);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic one(input string tag, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rs1,
                       input logic [XLEN-1:0] imm, input logic src, input logic [1:0] mode,
                       input logic [XLEN-1:0] exp_tgt);
        send(pc, rs1, imm, src, mode);
        idle();
        wait_out({tag, "_timeout"});
        chk(tag, tadd.iadder_out, exp_tgt);
        drain();
    endtask

    initial begin
        logic exp_mis102;
`ifdef MSRV32_TADD_MISALIGN_EN
        exp_mis102 = 1'b1;
`else
        exp_mis102 = 1'b0;
`endif
        tadd.flush_in      = 1'b0;
        tadd.in_valid_in   = 1'b0;
        tadd.pc_in         = '0;
        tadd.rs_1_in       = '0;
        tadd.imm_in        = '0;
        tadd.iadder_src_in = 1'b0;
        tadd.mode_in       = 2'b00;
        tadd.out_ready_in  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", tadd.out_valid_out, 1'b0);
        chk("rst_iadder", tadd.iadder_out, 0);
        chk("rst_misalign", tadd.misalign_out, 1'b0);
        chk("rst_in_ready", tadd.in_ready_out, 1'b0);

        // First handshake right after release, then exact latency
        rst = 1'b0;
        tadd.pc_in         = 32'h0000_1000;
        tadd.imm_in        = 32'h0000_0020;
        tadd.iadder_src_in = 1'b0;
        tadd.mode_in       = 2'b00;
        tadd.in_valid_in   = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", tadd.in_ready_out, 1'b1);
        @(posedge clk);
        #1;
        idle();
        for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
            chk("lat_early", tadd.out_valid_out, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("lat_valid", tadd.out_valid_out, 1'b1);
        chk("lat_add", tadd.iadder_out, 32'h0000_1020);
        drain();

        // Directed mode/base vectors
        one("jalr", 32'h0000_0000, 32'h0000_2001, 32'h0000_0004, 1'b1, 2'b01, 32'h0000_2004);
        one("pcrel_wrap", 32'hFFFF_FFFC, 32'h0000_5555, 32'h0000_0008, 1'b1, 2'b10, 32'h0000_0004);
        one("rsvd", 32'h0000_0010, 32'h0000_0300, 32'h0000_0003, 1'b1, 2'b11, 32'h0000_0303);
        one("add_pc_src0", 32'h0000_0040, 32'h0000_9999, 32'hFFFF_FFF0, 1'b0, 2'b00, 32'h0000_0030);
        send(32'h0, 32'h0000_0100, 32'h0000_0002, 1'b1, 2'b00);
        idle();
        wait_out("mis_timeout");
        chk("mis_tgt", tadd.iadder_out, 32'h0000_0102);
        chk("mis_flag", tadd.misalign_out, exp_mis102);
        drain();

        // Back-to-back stream with a 3-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send(32'h0000_4000 + 32'(i * 16), 32'h0000_8000 + 32'(i),
                         32'(i * 3), i[0], 2'(i));
                end
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                tadd.out_ready_in = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("full_ready", tadd.in_ready_out, 1'b0);
                    @(posedge clk);
                end
                #1;
                tadd.out_ready_in = 1'b1;
            end
        join
        drain();

        // Flush with two in flight and new input offered
        tadd.out_ready_in = 1'b0;
        send(32'h0000_A000, 32'h0, 32'h0000_0010, 1'b0, 2'b00);
        send(32'h0000_B000, 32'h0, 32'h0000_0020, 1'b0, 2'b00);
        idle();
        chk("pre_flush_ready", tadd.in_ready_out, 1'b0);
        tadd.pc_in         = 32'h0000_C000;
        tadd.imm_in        = 32'h0000_0044;
        tadd.iadder_src_in = 1'b0;
        tadd.mode_in       = 2'b00;
        tadd.in_valid_in   = 1'b1;
        tadd.flush_in      = 1'b1;
        tadd.out_ready_in  = 1'b1;
        @(posedge clk);
        #1;
        tadd.flush_in = 1'b0;
        chk("flush_clear", tadd.out_valid_out, 1'b0);
        send(32'h0000_C000, 32'h0, 32'h0000_0044, 1'b0, 2'b00);
        idle();
        wait_out("post_flush_timeout");
        chk("post_flush", tadd.iadder_out, 32'h0000_C044);
        drain();

        // Asynchronous reset with two in flight
        tadd.out_ready_in = 1'b0;
        send(32'h0000_D000, 32'h0, 32'h0000_0004, 1'b0, 2'b00);
        send(32'h0000_E000, 32'h0, 32'h0000_0008, 1'b0, 2'b00);
        idle();
        chk("pre_rst_valid", tadd.out_valid_out, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", tadd.out_valid_out, 1'b0);
        chk("midrst_iadder", tadd.iadder_out, 0);
        chk("midrst_ready", tadd.in_ready_out, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tadd.out_ready_in = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("post_rst_quiet", tadd.out_valid_out, 1'b0);
        end

        chk("sb_empty_end", 64'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/msrv32_target_adder_pipe.md
MSRV32_TARGET_ADDER_PIPE -- requirements
Module: msrv32_target_adder_pipe

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits (legal: 32, 64).
REQ-002 Parameter PIPE_DEPTH, default 2, register stages between input and output (legal: 1, 2).
REQ-003 ms_riscv32_mp_clk_in  input  1  clock; all state updates on its rising edge.
REQ-004 ms_riscv32_mp_rst_in  input  1  reset, asynchronous, active-high.
REQ-005 flush_in  input  1  synchronous pipeline kill.
REQ-006 in_valid_in  input  1  input transaction present.
REQ-007 in_ready_out  output  1  block accepts input this cycle.
REQ-008 pc_in  input  XLEN  program counter operand.
REQ-009 rs_1_in  input  XLEN  register operand.
REQ-010 imm_in  input  XLEN  sign-extended immediate.
REQ-011 iadder_src_in  input  1  base select: 0 = pc_in, 1 = rs_1_in.
REQ-012 mode_in  input  2  00 ADD, 01 JALR, 10 PCREL, 11 reserved.
REQ-013 out_valid_out  output  1  result present.
REQ-014 out_ready_in  input  1  downstream accepts result.
REQ-015 iadder_out  output  XLEN  computed target.
REQ-016 misalign_out  output  1  target not 4-byte aligned.

Function
REQ-017 Transfer on a port SHALL occur only in a cycle where valid and ready are both high.
REQ-018 Base SHALL be rs_1_in if iadder_src_in=1, else pc_in; mode PCREL SHALL force base = pc_in regardless of iadder_src_in.
REQ-019 Sum SHALL be base + imm_in modulo 2^XLEN; carry discarded, no overflow flag.
REQ-020 ADD and reserved mode 11 SHALL output the sum unchanged; JALR SHALL output the sum with bit 0 cleared.
REQ-021 Each stage SHALL hold a valid bit and payload; a stage SHALL load when empty or when its successor takes its contents in the same cycle.
REQ-022 in_ready_out SHALL equal (first stage empty) OR (first stage advancing), combinationally, with no dependence on in_valid_in.
REQ-023 With out_ready_in held high, latency SHALL be exactly PIPE_DEPTH cycles from input handshake to out_valid_out, at throughput one result per cycle.
REQ-024 With out_ready_in low and out_valid_out high, iadder_out and misalign_out SHALL hold stable; no transaction SHALL be lost or duplicated.
REQ-025 For PIPE_DEPTH=2, stage 1 SHALL register selected base, imm and mode; stage 2 SHALL register the final target.
REQ-026 flush_in high SHALL clear every stage valid bit at the next edge; in_ready_out SHALL be 0 that cycle; flush SHALL dominate simultaneous input and output handshakes.

Reset
REQ-027 Asserting ms_riscv32_mp_rst_in SHALL immediately clear all valid bits and payload registers, including mid-transaction.
REQ-028 During reset: out_valid_out=0, iadder_out=0, misalign_out=0, in_ready_out=0.
REQ-029 First input handshake SHALL be possible in the first clock cycle after reset deassertion.

Configuration
REQ-030 Macro MSRV32_TADD_MISALIGN_EN defined: misalign_out SHALL equal target bit 1 OR target bit 0 of the output-stage payload, registered alongside iadder_out.
REQ-031 Macro undefined: misalign_out SHALL be constant 0, and the alignment logic SHALL not exist.

Structure
REQ-032 Shared package msrv32_pkg SHALL hold the mode encodings (ADD, JALR, PCREL, RSVD) and the default XLEN constant.
REQ-033 One sub-module, msrv32_pipe_stage (valid/payload register with handshake, parametrised payload width), SHALL be instantiated PIPE_DEPTH times.

Verification
REQ-034 Reset mid-stream with 2 entries in flight -> out_valid_out drops to 0 immediately, iadder_out=0, no result emerges after release.
REQ-035 PIPE_DEPTH=2, pc=0x1000, imm=0x20, src=0, mode=ADD, out_ready_in=1 -> iadder_out=0x1020 valid exactly 2 cycles later.
REQ-036 rs_1=0x2001, imm=0x4, src=1, mode=JALR -> 0x2004; pc=0xFFFFFFFC, imm=0x8, mode=PCREL, src=1 -> 0x00000004 (wrap).
REQ-037 Stream 5 back-to-back inputs, out_ready_in low 3 cycles mid-stream -> all 5 results in order, outputs stable while stalled, in_ready_out low when full.
REQ-038 Flush with 2 in flight and in_valid_in high -> zero results emerge, next input after flush yields its correct result.
REQ-039 MSRV32_TADD_MISALIGN_EN defined, rs_1=0x100, imm=0x2, mode=ADD -> iadder_out=0x102, misalign_out=1; undefined -> misalign_out=0.
